// File: rtl/mux_arb_pkg.sv
// Shared constants and FSM state type for the 8-way round-robin mux arbiter.
package mux_arb_pkg;

    localparam int unsigned N_REQ  = 8;
    localparam int unsigned SEL_W  = 3;
    localparam int unsigned HOLD_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin picker: first set req bit at ptr, ptr+1, ... mod 8.
// Rotates req so ptr lands at bit 0, priority-encodes the lowest set bit,
// then adds ptr back to recover the absolute index.
module rr_pick8
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [SEL_W-1:0]   off;

    // Rotate right by ptr via a doubled vector, then find the lowest set bit.
    always_comb begin
        dbl   = {req, req} >> ptr;
        rot   = dbl[N_REQ-1:0];
        off   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (rot[i] && !found) begin
                found = 1'b1;
                off   = SEL_W'(i);
            end
        end
        idx = ptr + off;
    end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// 8:1 mux with round-robin arbiter: registered one-hot grant, binary select,
// and a combinational output tap of the granted input.
// Optional per-owner hold limit: define ARB_HOLD_LIMIT_EN to enable it.
module mux8_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] in,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             gnt_valid,
    output logic             out
);

    state_t           state_q, state_d;
    logic [N_REQ-1:0] gnt_d;
    logic [SEL_W-1:0] sel_d;
    logic             valid_d;
    logic [SEL_W-1:0] ptr, ptr_d;
    logic             found;
    logic [SEL_W-1:0] win;
    logic             take;
    logic             preempt;

`ifdef ARB_HOLD_LIMIT_EN
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_d;
    logic [N_REQ-1:0]  others;

    // Preempt the owner once it has held HOLD_MAX cycles and someone else waits.
    always_comb begin
        others       = req;
        others[sel]  = 1'b0;
        preempt      = (hold_cnt == HOLD_W'(HOLD_MAX)) && (|others);
    end
`else
    logic [HOLD_W-1:0] hold_max_unused;
    assign hold_max_unused = HOLD_W'(HOLD_MAX);
    assign preempt         = 1'b0;
`endif

    rr_pick8 u_pick (
        .req   (req),
        .ptr   (ptr),
        .found (found),
        .idx   (win)
    );

    // State, grant, select and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt       <= '0;
            sel       <= '0;
            gnt_valid <= 1'b0;
            ptr       <= '0;
`ifdef ARB_HOLD_LIMIT_EN
            hold_cnt  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            gnt       <= gnt_d;
            sel       <= sel_d;
            gnt_valid <= valid_d;
            ptr       <= ptr_d;
`ifdef ARB_HOLD_LIMIT_EN
            hold_cnt  <= hold_cnt_d;
`endif
        end
    end

    // Next-state logic: hold, hand over without a gap, or drop to idle.
    // Preemption needs no masking of the owner's bit: ptr is already sel+1,
    // so the owner has lowest priority and another pending bit always wins.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt;
        sel_d   = sel;
        valid_d = gnt_valid;
        ptr_d   = ptr;
        take    = 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
        hold_cnt_d = hold_cnt;
`endif
        case (state_q)
            IDLE: begin
                if (found) take = 1'b1;
            end
            GRANT: begin
                if (req[sel] && !preempt) begin
`ifdef ARB_HOLD_LIMIT_EN
                    if (hold_cnt != '1) hold_cnt_d = hold_cnt + HOLD_W'(1);
`endif
                end else if (found) begin
                    take = 1'b1;
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (take) begin
            state_d    = GRANT;
            gnt_d      = '0;
            gnt_d[win] = 1'b1;
            sel_d      = win;
            valid_d    = 1'b1;
            ptr_d      = win + SEL_W'(1);
`ifdef ARB_HOLD_LIMIT_EN
            hold_cnt_d = HOLD_W'(1);
`endif
        end
    end

    // Output tap of the granted input, forced low when nothing is granted.
    assign out = gnt_valid ? in[sel] : 1'b0;

endmodule
